// File: rtl/seg_approx_add_ctrl_pkg.sv
// Shared definitions for the segmented approximate adder controller.
//   - state_e : controller FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - clog2   : ceiling log2, used to size the segment index and approx_k
//   - nseg    : number of SEG-bit segments spanning a WIDTH-bit operand
package seg_approx_add_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Returns ceil(log2(v)); clog2(0) and clog2(1) both give 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/seg_approx_add_ctrl_pg.sv
// seg_pg_slice: combinational SEG-bit ripple adder built from per-bit
// propagate (a^b) and generate (a&b) cells.
// Ports:
//   a_s, b_s : SEG-bit operand slices
//   cin      : carry into bit 0
//   s        : SEG-bit slice sum
//   cout     : carry out of the top bit
module seg_pg_slice #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a_s,
  input  logic [SEG-1:0] b_s,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   c;

  assign p = a_s ^ b_s;
  assign g = a_s & b_s;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SEG); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s    = p ^ c[SEG-1:0];
  assign cout = c[SEG];

endmodule

// File: rtl/seg_approx_add_ctrl.sv
// seg_approx_add_ctrl: multi-cycle controller that walks one SEG-bit
// propagate/generate slice across a WIDTH-bit operand pair, LSB segment
// first, one segment per cycle. The carry leaving each of the lowest k_eff
// segments is dropped (segmented approximate addition); err records whether
// any dropped carry was 1.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (ready only in IDLE)
//   a, b              : WIDTH-bit operands
//   approx_k          : number of low segment boundaries to truncate
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout, err    : result, top carry out, truncation-lost-carry flag
//   busy              : FSM not in IDLE
module seg_approx_add_ctrl
  import seg_approx_add_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned SEG   = 8,
  localparam int unsigned NSEG  = nseg(WIDTH, SEG),
  localparam int unsigned KW    = clog2(NSEG) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    approx_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic             busy
);

  localparam int unsigned IW = (NSEG > 1) ? clog2(NSEG) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IW-1:0]    seg_idx_q, seg_idx_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [SEG-1:0]   seg_a, seg_b, seg_s;
  logic             seg_co;
  logic             drop_carry;
  logic             last_seg;

  // Select the operand slices for the current segment.
  always_comb begin
    seg_a = '0;
    seg_b = '0;
    for (int i = 0; i < int'(NSEG); i++) begin
      if (seg_idx_q == IW'(i)) begin
        seg_a = a_q[i*SEG +: SEG];
        seg_b = b_q[i*SEG +: SEG];
      end
    end
  end

  seg_pg_slice #(
    .SEG (SEG)
  ) u_slice (
    .a_s  (seg_a),
    .b_s  (seg_b),
    .cin  (carry_q),
    .s    (seg_s),
    .cout (seg_co)
  );

  assign drop_carry = int'(seg_idx_q) < int'(k_q);
  assign last_seg   = (seg_idx_q == IW'(NSEG - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    seg_idx_d = seg_idx_q;
    carry_d   = carry_q;
    err_d     = err_q;
    sum_d     = sum_q;
    cout_d    = cout_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          // The top boundary carry becomes cout, so at most NSEG-1 can drop.
          if (int'(approx_k) > int'(NSEG - 1)) begin
            k_d = KW'(NSEG - 1);
          end else begin
            k_d = approx_k;
          end
          seg_idx_d = '0;
          carry_d   = 1'b0;
          err_d     = 1'b0;
          sum_d     = '0;
          cout_d    = 1'b0;
          state_d   = StRun;
        end
      end

      StRun: begin
        for (int i = 0; i < int'(NSEG); i++) begin
          if (seg_idx_q == IW'(i)) begin
            sum_d[i*SEG +: SEG] = seg_s;
          end
        end
        if (drop_carry) begin
          carry_d = 1'b0;
          err_d   = err_q | seg_co;
        end else begin
          carry_d = seg_co;
        end
        if (last_seg) begin
          cout_d  = seg_co;
          state_d = StDone;
        end else begin
          seg_idx_d = seg_idx_q + 1'b1;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      seg_idx_q <= '0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      seg_idx_q <= seg_idx_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule
